// File: rtl/instr_encoder.sv
// RV64 instruction-word encoder: packs R/LD/SD/BEQ field requests into 32-bit words and queues them in a FIFO.
// Optional immediate range checking (sticky err) is enabled by defining ENC_RANGE_CHECK_EN.
module instr_encoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    in_op,
    input  logic [4:0]                    in_rd,
    input  logic [4:0]                    in_rs1,
    input  logic [4:0]                    in_rs2,
    input  logic [2:0]                    in_funct3,
    input  logic [6:0]                    in_funct7,
    input  logic [12:0]                   in_imm,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_instr,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] OP_R   = 2'b00;
    localparam logic [1:0] OP_LD  = 2'b01;
    localparam logic [1:0] OP_SD  = 2'b10;
    localparam logic [1:0] OP_BEQ = 2'b11;

    logic [31:0]   mem_reg [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [31:0]   enc_word;
    logic          push, pop;

    // in_ready comes only from registered occupancy, so a pop never frees a slot in the same cycle
    assign in_ready  = (count_reg != FULL_CNT);
    assign out_valid = (count_reg != '0);
    assign out_instr = out_valid ? mem_reg[rd_ptr_reg] : 32'h0;
    assign count     = count_reg;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        enc_word = 32'h0;
        case (in_op)
            OP_R:   enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            OP_LD:  enc_word = {in_imm[11:0], in_rs1, 3'b011, in_rd, 7'b0000011};
            OP_SD:  enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b011, in_imm[4:0], 7'b0100011};
            OP_BEQ: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                                in_imm[4:1], in_imm[11], 7'b1100011};
            default: enc_word = 32'h0;
        endcase
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = (wr_ptr_reg == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
        end
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage needs no reset: the pointers and count decide which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= enc_word;
        end
    end

`ifdef ENC_RANGE_CHECK_EN
    logic err_reg;
    logic range_bad;

    always_comb begin
        range_bad = 1'b0;
        case (in_op)
            OP_LD, OP_SD: range_bad = (in_imm[12] != in_imm[11]);
            OP_BEQ:       range_bad = in_imm[0];
            default:      range_bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (push && range_bad) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: queue-based reference model checked every cycle plus literal spot checks.
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [12:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [2:0]  count;
    logic        err;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] model_q[$];
    logic        model_err = 1'b0;

    instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .count(count), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] encode(input logic [1:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [2:0] f3, input logic [6:0] f7,
                                           input logic [12:0] imm);
        logic [31:0] w;
        w = 32'h0;
        if (op == 2'b00) begin
            w[31:25] = f7; w[24:20] = rs2; w[19:15] = rs1; w[14:12] = f3; w[11:7] = rd; w[6:0] = 7'h33;
        end else if (op == 2'b01) begin
            w[31:20] = imm[11:0]; w[19:15] = rs1; w[14:12] = 3'd3; w[11:7] = rd; w[6:0] = 7'h03;
        end else if (op == 2'b10) begin
            w[31:25] = imm[11:5]; w[24:20] = rs2; w[19:15] = rs1; w[14:12] = 3'd3;
            w[11:7] = imm[4:0]; w[6:0] = 7'h23;
        end else begin
            w[31] = imm[12]; w[30:25] = imm[10:5]; w[24:20] = rs2; w[19:15] = rs1;
            w[14:12] = 3'd0; w[11:8] = imm[4:1]; w[7] = imm[11]; w[6:0] = 7'h63;
        end
        return w;
    endfunction

    function automatic logic range_violation(input logic [1:0] op, input logic [12:0] imm);
        int v;
        v = $signed(imm);
        if (op == 2'b01 || op == 2'b10) return (v < -2048 || v > 2047);
        if (op == 2'b11) return (v % 2 != 0);
        return 1'b0;
    endfunction

    // Reference model: FIFO of expected words, updated with the inputs seen at each edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q.delete();
            model_err = 1'b0;
        end else begin
            bit do_push, do_pop;
            logic [31:0] w;
            do_push = in_valid && (model_q.size() < DEPTH);
            do_pop  = out_ready && (model_q.size() > 0);
            w = encode(in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                model_q.push_back(w);
`ifdef ENC_RANGE_CHECK_EN
                if (range_violation(in_op, in_imm)) model_err = 1'b1;
`endif
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] exp_w;
        exp_w = (model_q.size() > 0) ? model_q[0] : 32'h0;
        check("cyc_out_valid", {31'd0, out_valid}, {31'd0, model_q.size() > 0});
        check("cyc_out_instr", out_instr, exp_w);
        check("cyc_count", {29'd0, count}, 32'(model_q.size()));
        check("cyc_in_ready", {31'd0, in_ready}, {31'd0, model_q.size() < DEPTH});
        check("cyc_err", {31'd0, err}, {31'd0, model_err});
        $display("cycle t=%0t valid=%0b instr=0x%08h count=%0d ready=%0b err=%0b",
                 $time, out_valid, out_instr, count, in_ready, err);
    end

    task automatic drive(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [12:0] imm);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    logic exp_err_lit;

    initial begin
`ifdef ENC_RANGE_CHECK_EN
        exp_err_lit = 1'b1;
`else
        exp_err_lit = 1'b0;
`endif
        #3;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // R-format add x3, x1, x2
        @(negedge clk);
        drive(2'b00, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("radd_valid", {31'd0, out_valid}, 32'd1);
        check("radd_instr", out_instr, 32'h002081B3);
        check("radd_count", {29'd0, count}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("radd_drained", {29'd0, count}, 32'd0);

        // LD then SD back to back
        drive(2'b01, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 13'd8);
        @(negedge clk);
        check("ld_instr", out_instr, 32'h00813283);
        drive(2'b10, 5'd0, 5'd2, 5'd5, 3'd0, 7'd0, 13'd16);
        @(negedge clk);
        in_valid = 1'b0;
        check("sd_instr", out_instr, 32'h00513823);
        @(negedge clk);
        check("ldsd_empty", {31'd0, out_valid}, 32'd0);

        // BEQ with negative offset
        drive(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FFC);
        @(negedge clk);
        in_valid = 1'b0;
        check("beq_instr", out_instr, 32'hFE208EE3);
        @(negedge clk);

        // Fill, blocked push, pop with push attempt, drain across pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(2'b00, 5'(i + 1), 5'(i + 7), 5'(i + 12), 3'(i), 7'(i * 9), 13'd0);
            @(negedge clk);
        end
        drive(2'b01, 5'd31, 5'd30, 5'd0, 3'd0, 7'd0, 13'd100);
        check("full_count", {29'd0, count}, 32'd4);
        check("full_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("full_blocked", {29'd0, count}, 32'd4);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("full_pop_count", {29'd0, count}, 32'd3);
        check("full_ready_back", {31'd0, in_ready}, 32'd1);
        check("wrap_head", out_instr, encode(2'b00, 5'd2, 5'd8, 5'd13, 3'd1, 7'd9, 13'd0));
        repeat (4) @(negedge clk);
        check("drain_empty", {31'd0, out_valid}, 32'd0);

        // Reset with three words queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(2'b10, 5'd0, 5'(i), 5'(i + 3), 3'd0, 7'd0, 13'(i * 8));
            @(negedge clk);
        end
        check("pre_rst_count", {29'd0, count}, 32'd3);
        drive(2'b01, 5'd9, 5'd9, 5'd0, 3'd0, 7'd0, 13'd4);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_count", {29'd0, count}, 32'd0);
        check("mid_rst_instr", out_instr, 32'h0);
        @(negedge clk);
        drive(2'b01, 5'd6, 5'd4, 5'd0, 3'd0, 7'd0, 13'd12);
        rst = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("post_rst_word", out_instr, 32'h00C23303);
        check("post_rst_count", {29'd0, count}, 32'd1);
        @(negedge clk);
        check("post_rst_only", {31'd0, out_valid}, 32'd0);

        // Immediate range checking
        out_ready = 1'b0;
        drive(2'b01, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 13'h0800);
        @(negedge clk);
        check("range_ld_instr", out_instr, 32'h80013283);
        check("range_err", {31'd0, err}, {31'd0, exp_err_lit});
        out_ready = 1'b1;
        drive(2'b00, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 13'd0);
        @(negedge clk);
        drive(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'd7);
        @(negedge clk);
        in_valid = 1'b0;
        check("range_err_sticky", {31'd0, err}, {31'd0, exp_err_lit});
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("range_err_cleared", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
